// File: rtl/joybus_pkg.sv
// rtl/joybus_pkg.sv - shared joybus command codes, timing units and host FSM states
//
// Purpose: constants shared by the joybus host and the controller-side model.
//   CMD_*     command byte codes
//   *_LEN     response lengths in bytes for the standard commands
//   *_US      bit-cell timing in microseconds
//   joy_state_t  host transaction state encoding
package joybus_pkg;

    localparam logic [7:0] CMD_INFO  = 8'h00;
    localparam logic [7:0] CMD_POLL  = 8'h01;
    localparam logic [7:0] CMD_RESET = 8'hFF;

    localparam int INFO_LEN = 3;
    localparam int POLL_LEN = 4;

    localparam int BIT_US    = 4;
    localparam int SHORT_US  = 1;
    localparam int LONG_US   = 3;
    localparam int SAMPLE_US = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_LOW,
        S_TX_HIGH,
        S_TX_STOP,
        S_RX_WAIT,
        S_RX_SAMPLE,
        S_RX_STOP,
        S_DONE
    } joy_state_t;

endpackage

// File: rtl/joybus_line_sync.sv
// rtl/joybus_line_sync.sv - two-flop synchronizer with falling-edge pulse for the joybus line
//
// Ports:
//   clk      in   system clock
//   reset_l  in   asynchronous active-low reset
//   line_in  in   raw asynchronous line level
//   line     out  synchronized line level (2 cycles latency)
//   fall     out  one-cycle pulse when the synchronized line goes high->low
module joybus_line_sync (
    input  logic clk,
    input  logic reset_l,
    input  logic line_in,
    output logic line,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Flops reset to 1: an idle bus is pulled high, so no false edge at reset release.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign line = sync;
    assign fall = prev & ~sync;

endmodule

// File: rtl/joybus_host.sv
// rtl/joybus_host.sv - host-side joybus initiator: serialises a command, deserialises the response
//
// Ports:
//   clk, reset_l         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  start handshake (ready only in IDLE)
//   cmd_data[23:0]       command bytes, byte0 in [23:16], sent MSB-first
//   cmd_len[1:0]         bytes to send, 1..3 (0 behaves as 1)
//   rx_len[5:0]          response bytes expected, 0..MAX_RX
//   rx_data/rx_valid     received byte and its one-cycle strobe
//   done/timeout         end-of-transaction strobe; timeout qualifies it
//   rx_count[5:0]        whole bytes received, held until the next start
//   joy_in               raw line level
//   joy_oe               1 = pull the open-drain line low
module joybus_host
    import joybus_pkg::*;
#(
    parameter int CLKS_PER_US = 16,
    parameter int TIMEOUT_US  = 64,
    parameter int MAX_RX      = 32
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_data,
    input  logic [1:0]  cmd_len,
    input  logic [5:0]  rx_len,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        done,
    output logic        timeout,
    output logic [5:0]  rx_count,
    input  logic        joy_in,
    output logic        joy_oe
);

    localparam int TW = $clog2(TIMEOUT_US * CLKS_PER_US + 1) + 1;

    localparam logic [TW-1:0] SHORT_CYC   = TW'(SHORT_US * CLKS_PER_US);
    localparam logic [TW-1:0] LONG_CYC    = TW'(LONG_US * CLKS_PER_US);
    localparam logic [TW-1:0] BIT_CYC     = TW'(BIT_US * CLKS_PER_US);
    localparam logic [TW-1:0] SAMPLE_CYC  = TW'(SAMPLE_US * CLKS_PER_US);
    localparam logic [TW-1:0] TIMEOUT_CYC = TW'(TIMEOUT_US * CLKS_PER_US);
    localparam logic [TW-1:0] ONE         = TW'(1);
    localparam logic [5:0]    MAX_RX_L    = 6'(MAX_RX);

    joy_state_t    state;
    joy_state_t    state_n;
    logic [TW-1:0] timer;

    logic [23:0]   tx_shift;
    logic [4:0]    tx_bit;
    logic [1:0]    tx_len;
    logic [5:0]    rx_target;
    logic [6:0]    rx_shift;
    logic [2:0]    rx_bit;
    logic          to_q;

    logic          line_s;
    logic          line_fall;

    logic          accept;
    logic          bit_done;
    logic          sample_now;
    logic          timer_clr;
    logic          to_hit;

    logic [TW-1:0] low_cyc;
    logic [TW-1:0] high_cyc;
    logic          tx_last;
    logic          byte_last;

    joybus_line_sync u_line_sync (
        .clk     (clk),
        .reset_l (reset_l),
        .line_in (joy_in),
        .line    (line_s),
        .fall    (line_fall)
    );

    // Bit 1 is a short low then long high; bit 0 the reverse. Cell length is fixed.
    assign low_cyc   = tx_shift[23] ? SHORT_CYC : LONG_CYC;
    assign high_cyc  = BIT_CYC - low_cyc;
    assign tx_last   = (tx_bit == ({tx_len, 3'b000} - 5'd1));
    assign byte_last = (rx_bit == 3'd7) && ((rx_count + 6'd1) == rx_target);

    // Decoded straight from the state register so an asynchronous reset
    // releases the line without waiting for a clock edge.
    assign joy_oe    = (state == S_TX_LOW) || (state == S_TX_STOP);
    assign cmd_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign timeout   = to_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            if ((state_n != state) || timer_clr) begin
                timer <= '0;
            end else begin
                timer <= timer + ONE;
            end
        end
    end

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        bit_done   = 1'b0;
        sample_now = 1'b0;
        timer_clr  = 1'b0;
        to_hit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_n = S_TX_LOW;
                end
            end
            S_TX_LOW: begin
                if (timer == low_cyc - ONE) begin
                    state_n = S_TX_HIGH;
                end
            end
            S_TX_HIGH: begin
                if (timer == high_cyc - ONE) begin
                    bit_done = 1'b1;
                    state_n  = tx_last ? S_TX_STOP : S_TX_LOW;
                end
            end
            S_TX_STOP: begin
                if (timer == SHORT_CYC - ONE) begin
                    state_n = (rx_target == 6'd0) ? S_DONE : S_RX_WAIT;
                end
            end
            S_RX_WAIT: begin
                // The timer runs regardless of line level, so a line stuck
                // low also expires here.
                if (line_fall) begin
                    state_n = S_RX_SAMPLE;
                end else if (timer == TIMEOUT_CYC - ONE) begin
                    to_hit  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_RX_SAMPLE: begin
                if (timer == SAMPLE_CYC - ONE) begin
                    sample_now = 1'b1;
                    state_n    = byte_last ? S_RX_STOP : S_RX_WAIT;
                end
            end
            S_RX_STOP: begin
                // Any low level (stop bit or stray edges) restarts the
                // high-time measurement.
                if (!line_s) begin
                    timer_clr = 1'b1;
                end else if (timer == SAMPLE_CYC - ONE) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            tx_shift  <= '0;
            tx_bit    <= '0;
            tx_len    <= 2'd1;
            rx_target <= '0;
            rx_shift  <= '0;
            rx_bit    <= '0;
            rx_count  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            to_q     <= to_hit;
            if (accept) begin
                tx_shift  <= cmd_data;
                tx_bit    <= '0;
                tx_len    <= (cmd_len == 2'd0) ? 2'd1 : cmd_len;
                rx_target <= (rx_len > MAX_RX_L) ? MAX_RX_L : rx_len;
                rx_bit    <= '0;
                rx_count  <= '0;
            end
            if (bit_done) begin
                tx_shift <= {tx_shift[22:0], 1'b0};
                tx_bit   <= tx_bit + 5'd1;
            end
            if (sample_now) begin
                rx_shift <= {rx_shift[5:0], line_s};
                rx_bit   <= rx_bit + 3'd1;
                if (rx_bit == 3'd7) begin
                    rx_valid <= 1'b1;
                    rx_data  <= {rx_shift, line_s};
                    rx_count <= rx_count + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_joybus_host.sv
// tb/tb_joybus_host.sv - scoreboard bench for joybus_host with a behavioural controller responder
module tb_joybus_host;
    import joybus_pkg::*;

    localparam int CPU     = 4;
    localparam int TMO_US  = 64;
    localparam int TMO_CYC = TMO_US * CPU;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_data;
    logic [1:0]  cmd_len;
    logic [5:0]  rx_len;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        done;
    logic        timeout;
    logic [5:0]  rx_count;
    logic        joy_in;
    logic        joy_oe;
    logic        resp_low;

    // Open-drain bus with pull-up: low if either side pulls.
    assign joy_in = ~(joy_oe | resp_low);

    always #5 clk = ~clk;

    joybus_host #(
        .CLKS_PER_US (CPU),
        .TIMEOUT_US  (TMO_US),
        .MAX_RX      (32)
    ) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .rx_len    (rx_len),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .done      (done),
        .timeout   (timeout),
        .rx_count  (rx_count),
        .joy_in    (joy_in),
        .joy_oe    (joy_oe)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         n_done = 0;
    int         done_cyc = 0;
    int         rel_cyc = 0;
    logic [7:0] exp_rx[$];
    logic [6:0] exp_done[$];
    logic [7:0] resp_bytes[$];
    int         resp_nbits = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_l && rx_valid) begin
            if (exp_rx.size() == 0) chk("rx_unexpected", 32'(rx_valid), 32'd0);
            else                    chk("rx_byte", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
        if (reset_l && done) begin
            n_done++;
            done_cyc = cyc;
            if (exp_done.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
            else                      chk("done_status", 32'({timeout, rx_count}), 32'(exp_done.pop_front()));
        end
    end

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (joy_oe === lvl && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Measures each driven bit cell; returns at the first released cycle after the stop.
    task automatic tx_check(input logic [23:0] data, input logic [1:0] len);
        int nb;
        int cnt;
        int guard;
        logic bt;
        nb    = ((len == 2'd0) ? 1 : int'(len)) * 8;
        guard = 0;
        while (joy_oe !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < nb; i++) begin
            bt = data[23 - i];
            run_len(1'b1, cnt);
            chk($sformatf("tx_bit%0d_low", i), 32'(cnt), 32'(bt ? CPU : 3 * CPU));
            run_len(1'b0, cnt);
            chk($sformatf("tx_bit%0d_high", i), 32'(cnt), 32'(bt ? 3 * CPU : CPU));
        end
        run_len(1'b1, cnt);
        chk("tx_stop_low", 32'(cnt), 32'(CPU));
        rel_cyc = cyc;
    endtask

    task automatic respond();
        logic [7:0] b;
        logic       bt;
        repeat (2 * CPU) @(negedge clk);
        for (int i = 0; i < resp_nbits; i++) begin
            b  = resp_bytes[i / 8];
            bt = b[7 - (i % 8)];
            resp_low = 1'b1;
            repeat (bt ? CPU : 3 * CPU) @(negedge clk);
            resp_low = 1'b0;
            repeat (bt ? 3 * CPU : CPU) @(negedge clk);
        end
        if (resp_nbits % 8 == 0) begin
            resp_low = 1'b1;
            repeat (2 * CPU) @(negedge clk);
            resp_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int start);
        int g;
        g = 0;
        while (n_done == start && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", 32'(n_done - start), 32'd1);
    endtask

    task automatic do_txn(input logic [23:0] data, input logic [1:0] len, input logic [5:0] rxl,
                          input logic exp_to, input int exp_cnt);
        int start;
        start = n_done;
        for (int i = 0; i < exp_cnt; i++) exp_rx.push_back(resp_bytes[i]);
        exp_done.push_back({exp_to, 6'(exp_cnt)});
        @(negedge clk);
        cmd_data  = data;
        cmd_len   = len;
        rx_len    = rxl;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        tx_check(data, len);
        if (resp_nbits > 0) respond();
        wait_done(start);
        chk("rx_leftover", 32'(exp_rx.size()), 32'd0);
        @(negedge clk);
        chk("ready_after_done", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int start;
        reset_l   = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_len   = '0;
        rx_len    = '0;
        resp_low  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_joy_oe",    32'(joy_oe),    32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rx_valid",  32'(rx_valid),  32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_timeout",   32'(timeout),   32'd0);
        chk("rst_rx_count",  32'(rx_count),  32'd0);
        chk("rst_rx_data",   32'(rx_data),   32'd0);
        reset_l = 1'b1;
        repeat (3) @(negedge clk);

        // Poll: START, L+R, X=5, Y=4
        resp_bytes = '{8'h10, 8'h30, 8'h05, 8'h04};
        resp_nbits = 32;
        do_txn({CMD_POLL, 16'h0}, 2'd1, 6'(POLL_LEN), 1'b0, 4);

        // Info, with cmd_len 0 standing in for 1
        resp_bytes = '{8'h05, 8'h00, 8'h02};
        resp_nbits = 24;
        do_txn({CMD_INFO, 16'h0}, 2'd0, 6'(INFO_LEN), 1'b0, 3);

        // Three-byte command, single-byte response
        resp_bytes = '{8'h7E};
        resp_nbits = 8;
        do_txn(24'hC3_5A_81, 2'd3, 6'd1, 1'b0, 1);

        // No device
        resp_bytes.delete();
        resp_nbits = 0;
        do_txn({CMD_POLL, 16'h0}, 2'd1, 6'(POLL_LEN), 1'b1, 0);
        chk("tmo_latency", 32'(done_cyc - rel_cyc), 32'(TMO_CYC));

        // Short response: 2 bytes plus 3 bits
        resp_bytes = '{8'hA5, 8'h3C, 8'hE0};
        resp_nbits = 19;
        do_txn({CMD_POLL, 16'h0}, 2'd1, 6'(POLL_LEN), 1'b1, 2);

        // Reset during the 2nd bit's low phase
        start = n_done;
        @(negedge clk);
        cmd_data  = {CMD_POLL, 16'h0};
        cmd_len   = 2'd1;
        rx_len    = 6'(POLL_LEN);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4 * CPU + 5) @(negedge clk);
        chk("mid_tx_low", 32'(joy_oe), 32'd1);
        #1 reset_l = 1'b0;
        #1;
        chk("rst_async_release", 32'(joy_oe), 32'd0);
        chk("rst_async_ready",   32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);
        repeat (TMO_CYC + 100) @(negedge clk);
        chk("no_done_after_reset", 32'(n_done - start), 32'd0);

        // Back-to-back with cmd_valid held high; the first has no response phase
        start      = n_done;
        resp_bytes = '{8'h05, 8'h00, 8'h01};
        resp_nbits = 24;
        exp_done.push_back({1'b0, 6'd0});
        for (int i = 0; i < 3; i++) exp_rx.push_back(resp_bytes[i]);
        exp_done.push_back({1'b0, 6'd3});
        @(negedge clk);
        cmd_data  = {CMD_POLL, 16'h0};
        cmd_len   = 2'd1;
        rx_len    = 6'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_data  = {CMD_RESET, 16'h0};
        rx_len    = 6'(INFO_LEN);
        tx_check({CMD_POLL, 16'h0}, 2'd1);
        chk("b2b_done",          32'(done),      32'd1);
        chk("b2b_ready_in_done", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("b2b_ready_rise",    32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("b2b_restart",       32'(joy_oe),    32'd1);
        cmd_valid = 1'b0;
        tx_check({CMD_RESET, 16'h0}, 2'd1);
        respond();
        wait_done(start + 1);
        chk("b2b_rx_leftover", 32'(exp_rx.size()), 32'd0);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/joybus_host.md
Name: joybus_host

Overview:
- Host-side (PIF-side) initiator for the N64 single-wire joybus.
- Serialises a 1–3 byte command onto one controller port, then deserialises the controller's response into a byte stream.
- One instance per port (joy1..joy4) inside the PIF top; it is the counterpart of the controller-side responder.
- The line is open-drain: the block only ever pulls low or releases. The tristate lives at the top level.

Parameters:
- CLKS_PER_US, 16, clk cycles per 1 µs joybus time unit (bench uses 4).
- TIMEOUT_US, 64, µs of line-high with no falling edge before a response is declared absent.
- MAX_RX, 32, maximum response bytes accepted.

Ports:
- clk  in  1  system clock.
- reset_l  in  1  asynchronous active-low reset.
- cmd_valid  in  1  start transaction; sampled only when cmd_ready=1.
- cmd_ready  out  1  high in IDLE.
- cmd_data  in  24  command bytes, byte0 in [23:16], sent MSB-first.
- cmd_len  in  2  command bytes to send, 1..3 (0 treated as 1).
- rx_len  in  6  response bytes expected, 0..MAX_RX.
- rx_data  out  8  received byte.
- rx_valid  out  1  one-cycle strobe per received byte.
- done  out  1  one-cycle strobe at transaction end.
- timeout  out  1  qualifies done: response missing or incomplete.
- rx_count  out  6  bytes received; valid at done, held until next start.
- joy_in  in  1  raw line level (asynchronous).
- joy_oe  out  1  1 = pull line low.

Behaviour:
- Reset: joy_oe=0, cmd_ready=1, rx_valid=0, done=0, timeout=0, rx_count=0, rx_data=0.
- Reset asserted mid-transaction releases the line immediately (asynchronous) and returns the block to IDLE.
- joy_in passes through a 2-flop synchronizer and then a falling-edge detector. Synchronizer latency is 2 cycles.
- One cycle timer is compared against multiples of CLKS_PER_US; it reloads on every state change.
- IDLE: on cmd_valid&cmd_ready, latch cmd_data/cmd_len/rx_len, clear rx_count, go to TX_LOW the next cycle.
- TX_LOW/TX_HIGH, per bit:
  - bit 0: low for 3 µs, then high for 1 µs.
  - bit 1: low for 1 µs, then high for 3 µs.
  - Cell length is exactly 4*CLKS_PER_US cycles.
- After cmd_len*8 bits go to TX_STOP: low for 1 µs, then release and enter RX_WAIT.
- If rx_len=0, skip RX and go to DONE instead.
- RX_WAIT:
  - A falling edge starts a bit and moves to RX_SAMPLE.
  - Timer reaching TIMEOUT_US: DONE with timeout=1.
  - Line stuck low for TIMEOUT_US also times out.
- RX_SAMPLE:
  - Sample the synchronized line 2 µs after the falling edge: high = 1, low = 0.
  - Shift the sample in MSB-first.
  - On the 8th bit, pulse rx_valid with rx_data and increment rx_count.
  - Then return to RX_WAIT.
- After rx_len bytes, enter RX_STOP. This absorbs the controller stop bit (up to 2 µs low): wait until the line has been high for 2 µs, then DONE.
- Extra falling edges after rx_len bytes are ignored; no extra rx_valid is issued.
- DONE: pulse done for one cycle (timeout valid in the same cycle), then IDLE. cmd_ready rises the cycle after done.
- While busy, cmd_valid is ignored.
- Timeout mid-byte: the partial byte is discarded and rx_count reports whole bytes only.

Decomposition:
- Shared package joybus_pkg holds:
  - command constants CMD_INFO=8'h00, CMD_POLL=8'h01, CMD_RESET=8'hFF;
  - response lengths INFO_LEN=3, POLL_LEN=4;
  - the state enum;
  - timing constants in µs (BIT_US=4, SHORT_US=1, LONG_US=3, SAMPLE_US=2).
- One sub-module, joybus_line_sync: 2-flop synchronizer plus falling-edge pulse. It will be reused by the controller model.

Test Plan (CLKS_PER_US=4):
- Poll: cmd 0x01, len 1, rx_len 4; responder holds START, L, R, X=5, Y=4. Required: joy_oe shows 7 bit cells of 12 low/4 high cycles, one cell of 4 low/12 high, then a 4-cycle stop. rx_valid bytes are 0x10,0x30,0x05,0x04; done with rx_count=4, timeout=0.
- Info: cmd 0x00, rx_len 3; responder returns 0x05,0x00,0x02. Required: 3 rx_valid, done, timeout=0.
- No device (line pulled high only): cmd 0x01. Required: done with timeout=1 exactly TIMEOUT_US*4 cycles after stop release, rx_count=0.
- Short response: responder stops after 2 bytes plus 3 bits of rx_len 4. Required: done with timeout=1, rx_count=2, exactly 2 rx_valid.
- Reset mid-TX: assert reset_l low during the 2nd bit's low phase. Required: joy_oe=0 in the same cycle, cmd_ready=1 after release, and no done.
- Back-to-back: cmd_valid held high across done. Required: second transaction starts the cycle after cmd_ready rises; cmd_valid ignored while busy.
